// File: rtl/drum_pad_encoder_pkg.sv
// drum_pkg: shared constants for the drum pad encoder.
// FSM state encodings, bit positions inside the Entrada command word and the
// pad count used by the conditioning and picking logic.
package drum_pkg;

    // FSM states, kept as plain constants so older tools can read them
    localparam logic [1:0] ST_WAIT_START = 2'd0;
    localparam logic [1:0] ST_RUN        = 2'd1;
    localparam logic [1:0] ST_PAD_HOLD   = 2'd2;

    // Bit positions inside the Entrada word
    localparam int E_START = 0;
    localparam int E_BAND  = 1;
    localparam int E_PAD0  = 2;

    // Number of drum pads and total conditioned inputs (start + band + pads)
    localparam int PAD_COUNT   = 5;
    localparam int INPUT_COUNT = PAD_COUNT + 2;

    // Convert a zero-based pad index into the 1-based pad number the painter reports
    function automatic logic [2:0] pad_number(input logic [2:0] idx);
        return idx + 3'd1;
    endfunction

endpackage

// File: rtl/drum_pad_encoder_debouncer.sv
// input_debouncer: conditions one asynchronous raw input.
// Two-flop synchroniser, then a level that changes only after the synchronised
// value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
// Also produces a one-cycle rise pulse for each accepted 0->1 change.
module input_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEBOUNCE_W      = 20
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);

    logic                  sync_a;
    logic                  sync_b;
    logic                  stable;
    logic                  stable_d;
    logic [DEBOUNCE_W-1:0] count;

    // Bring the raw input into the clock domain through two flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
        end
    end

    // Count consecutive differing cycles and accept the new level on the last one
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable <= 1'b0;
            count  <= '0;
        end else if (sync_b != stable) begin
            if (count == DEBOUNCE_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync_b;
                count  <= '0;
            end else begin
                count <= count + DEBOUNCE_W'(1);
            end
        end else begin
            count <= '0;
        end
    end

    // Delayed copy of the debounced level used to find rising edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_d <= 1'b0;
        end else begin
            stable_d <= stable;
        end
    end

    assign level = stable;
    assign rise  = stable & ~stable_d;

endmodule

// File: rtl/drum_pad_encoder.sv
// drum_pad_encoder: front end of the band painter.
// Debounces the start key, the static-band switch and five drum pads, then
// drives the registered one-hot Entrada word: bit0 start, bit1 band, bits6:2 pads.
// At most one pad bit is high at a time, held for HOLD_CYCLES per accepted hit.
module drum_pad_encoder
    import drum_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int DEBOUNCE_W      = 20,
    parameter int HOLD_CYCLES     = 8,
    parameter int HOLD_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       sw_band,
    input  logic [4:0] pad,
    output logic [6:0] entrada,
    output logic       hit_strobe,
    output logic [2:0] hit_id,
    output logic       running
);

    logic [INPUT_COUNT-1:0] raw_bus;
    logic [INPUT_COUNT-1:0] level_bus;
    logic [INPUT_COUNT-1:0] rise_bus;

    logic                   start_rise;
    logic                   band_level;
    logic [PAD_COUNT-1:0]   pad_rise;

    logic                   pad_hit;
    logic [2:0]             pick_idx;

    logic [1:0]             state;
    logic [1:0]             state_n;
    logic [2:0]             sel;
    logic [2:0]             sel_n;
    logic [HOLD_W-1:0]      timer;
    logic [HOLD_W-1:0]      timer_n;
    logic [6:0]             entrada_n;
    logic                   hit_strobe_n;
    logic [2:0]             hit_id_n;
    logic                   running_n;

    logic                   unused_conditioning;

    assign raw_bus = {pad, sw_band, btn_start};

    genvar g;
    generate
        for (g = 0; g < INPUT_COUNT; g++) begin : g_cond
            input_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .DEBOUNCE_W     (DEBOUNCE_W)
            ) u_debouncer (
                .clk  (clk),
                .reset(reset),
                .raw  (raw_bus[g]),
                .level(level_bus[g]),
                .rise (rise_bus[g])
            );
        end
    endgenerate

    assign start_rise = rise_bus[E_START];
    assign band_level = level_bus[E_BAND];
    assign pad_rise   = rise_bus[E_PAD0 +: PAD_COUNT];

    // Only the start/pad edges and the band level drive the FSM
    assign unused_conditioning = ^{level_bus[E_PAD0 +: PAD_COUNT], level_bus[E_START], rise_bus[E_BAND]};

    // Priority picker: scanning from the top down leaves the lowest rising pad selected
    always_comb begin
        pad_hit  = 1'b0;
        pick_idx = 3'd0;
        for (int i = PAD_COUNT - 1; i >= 0; i--) begin
            if (pad_rise[i]) begin
                pad_hit  = 1'b1;
                pick_idx = 3'(i);
            end
        end
    end

    // Next-state, hold timer and next output word, all registered together below
    always_comb begin
        state_n      = state;
        sel_n        = sel;
        timer_n      = timer;
        entrada_n    = '0;
        hit_strobe_n = 1'b0;
        hit_id_n     = 3'd0;
        running_n    = running;
        case (state)
            ST_WAIT_START: begin
                if (start_rise) begin
                    entrada_n[E_START] = 1'b1;
                    running_n          = 1'b1;
                    state_n            = ST_RUN;
                end
            end
            ST_RUN, ST_PAD_HOLD: begin
                if (pad_hit) begin
                    state_n      = ST_PAD_HOLD;
                    sel_n        = pick_idx;
                    timer_n      = HOLD_W'(HOLD_CYCLES - 1);
                    hit_strobe_n = 1'b1;
                    hit_id_n     = pad_number(pick_idx);
                end else if (state == ST_PAD_HOLD) begin
                    if (timer == '0) begin
                        state_n = ST_RUN;
                    end else begin
                        timer_n = timer - HOLD_W'(1);
                    end
                end
                entrada_n[E_BAND] = band_level;
                for (int i = 0; i < PAD_COUNT; i++) begin
                    entrada_n[E_PAD0 + i] = (state_n == ST_PAD_HOLD) && (sel_n == 3'(i));
                end
            end
            default: begin
                state_n = ST_WAIT_START;
                timer_n = '0;
            end
        endcase
    end

    // State and output registers; reset drops any hit in progress immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_WAIT_START;
            sel        <= 3'd0;
            timer      <= '0;
            entrada    <= '0;
            hit_strobe <= 1'b0;
            hit_id     <= 3'd0;
            running    <= 1'b0;
        end else begin
            state      <= state_n;
            sel        <= sel_n;
            timer      <= timer_n;
            entrada    <= entrada_n;
            hit_strobe <= hit_strobe_n;
            hit_id     <= hit_id_n;
            running    <= running_n;
        end
    end

endmodule

// File: tb/tb_drum_pad_encoder.sv
// tb_drum_pad_encoder: scoreboard bench for the drum pad encoder.
// A behavioural model turns the raw inputs seen at each clock edge into the
// expected Entrada word; a monitor on the falling edge compares the DUT against it.
module tb_drum_pad_encoder;

    localparam int DB   = 4;
    localparam int HOLD = 8;
    localparam int HW   = DB + 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_start = 1'b0;
    logic       sw_band = 1'b0;
    logic [4:0] pad = 5'b0;
    logic [6:0] entrada;
    logic       hit_strobe;
    logic [2:0] hit_id;
    logic       running;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [6:0] e;
        logic       run;
        logic       strobe;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] hit_q[$];

    drum_pad_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .DEBOUNCE_W     (20),
        .HOLD_CYCLES    (HOLD),
        .HOLD_W         (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_start (btn_start),
        .sw_band   (sw_band),
        .pad       (pad),
        .entrada   (entrada),
        .hit_strobe(hit_strobe),
        .hit_id    (hit_id),
        .running   (running)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation and record the outcome
    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one set of raw inputs just after a rising edge and hold it for n cycles
    task automatic applyStimulus(input logic s, input logic b, input logic [4:0] p, input int n);
        @(posedge clk);
        #1;
        btn_start = s;
        sw_band   = b;
        pad       = p;
        repeat (n - 1) @(posedge clk);
    endtask

    // Assert the active-low reset for n cycles with all raw inputs idle
    task automatic pulseReset(input int n);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        btn_start = 1'b0;
        sw_band   = 1'b0;
        pad       = 5'b0;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Reference model state: raw sample history, debounced levels, hit bookkeeping
    logic [HW-1:0] hist [7];
    logic [6:0]    lvl_now;
    logic [6:0]    lvl_prev;
    bit            started;
    int            sel;
    int            hold_left;

    // Reference model: a level flips once the raw input, seen two samples late,
    // has disagreed with it for DB samples in a row; hits follow the hold rules
    always @(posedge clk) begin : model
        logic [6:0] raw_now;
        logic [6:0] rise_now;
        logic [6:0] new_lvl;
        exp_t       x;
        int         pick;
        bit         all_diff;
        if (!reset) begin
            for (int i = 0; i < 7; i++) hist[i] = '0;
            lvl_now   = '0;
            lvl_prev  = '0;
            started   = 0;
            sel       = 0;
            hold_left = 0;
        end else begin
            raw_now  = {pad, sw_band, btn_start};
            rise_now = lvl_now & ~lvl_prev;
            x        = '0;
            if (!started) begin
                if (rise_now[0]) begin
                    x.e     = 7'b0000001;
                    started = 1;
                end
            end else begin
                pick = -1;
                for (int p = 4; p >= 0; p--) if (rise_now[2 + p]) pick = p;
                if (pick >= 0) begin
                    sel       = pick;
                    hold_left = HOLD;
                    x.strobe  = 1'b1;
                    hit_q.push_back(3'(pick + 1));
                end
                if (hold_left > 0) begin
                    x.e[2 + sel] = 1'b1;
                    hold_left--;
                end
                x.e[1] = lvl_now[1];
            end
            x.run = started;
            exp_q.push_back(x);
            for (int i = 0; i < 7; i++) begin
                hist[i]  = {hist[i][HW-2:0], raw_now[i]};
                all_diff = 1;
                for (int j = 2; j < HW; j++) if (hist[i][j] == lvl_now[i]) all_diff = 0;
                new_lvl[i] = all_diff ? ~lvl_now[i] : lvl_now[i];
            end
            lvl_prev = lvl_now;
            lvl_now  = new_lvl;
        end
    end

    // Monitor: on each falling edge pop the expectation and compare all outputs
    always @(negedge clk) begin : monitor
        exp_t       x;
        logic [2:0] want_id;
        logic       ok;
        ok = ($countones(entrada[6:2]) <= 1) && !(entrada[0] && (|entrada[6:1]));
        checkOutput("invariant", {7'b0, ok}, 8'd1);
        if (!reset) begin
            exp_q.delete();
            hit_q.delete();
            checkOutput("reset_entrada", {1'b0, entrada}, 8'h00);
            checkOutput("reset_running", {7'b0, running}, 8'h00);
            checkOutput("reset_strobe", {7'b0, hit_strobe}, 8'h00);
        end else if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            checkOutput("entrada", {1'b0, entrada}, {1'b0, x.e});
            checkOutput("running", {7'b0, running}, {7'b0, x.run});
            checkOutput("hit_strobe", {7'b0, hit_strobe}, {7'b0, x.strobe});
            if (hit_strobe) begin
                if (hit_q.size() == 0) begin
                    checkOutput("hit_unexpected", {5'b0, hit_id}, 8'h00);
                end else begin
                    want_id = hit_q.pop_front();
                    checkOutput("hit_id", {5'b0, hit_id}, {5'b0, want_id});
                end
            end else begin
                checkOutput("hit_id_idle", {5'b0, hit_id}, 8'h00);
            end
        end
    end

    // Stimulus: directed scenarios, random traffic, a reset mid-hold, then more traffic
    initial begin : stimulus
        logic [4:0] rp;
        logic       rb;
        logic       rs;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        applyStimulus(1'b0, 1'b0, 5'b00101, 12);
        applyStimulus(1'b0, 1'b1, 5'b00000, 8);
        applyStimulus(1'b0, 1'b0, 5'b00000, 8);

        applyStimulus(1'b1, 1'b0, 5'b00000, 12);
        applyStimulus(1'b1, 1'b0, 5'b00100, 20);
        applyStimulus(1'b1, 1'b0, 5'b00000, 12);
        applyStimulus(1'b1, 1'b0, 5'b00010, 3);
        applyStimulus(1'b1, 1'b0, 5'b00000, 10);
        applyStimulus(1'b1, 1'b0, 5'b10001, 3);
        applyStimulus(1'b1, 1'b0, 5'b11001, 15);
        applyStimulus(1'b1, 1'b0, 5'b00000, 12);
        applyStimulus(1'b1, 1'b1, 5'b00010, 20);
        applyStimulus(1'b1, 1'b0, 5'b00000, 12);

        for (int r = 0; r < 250; r++) begin
            rp = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            rb = ($urandom_range(0, 3) == 0) ? ~sw_band : sw_band;
            rs = ($urandom_range(0, 9) == 0);
            applyStimulus(rs, rb, rp, $urandom_range(1, 12));
        end

        applyStimulus(1'b1, 1'b0, 5'b00000, 12);
        applyStimulus(1'b1, 1'b0, 5'b00100, 10);
        pulseReset(2);
        applyStimulus(1'b0, 1'b0, 5'b01010, 15);
        applyStimulus(1'b0, 1'b1, 5'b00000, 10);
        applyStimulus(1'b1, 1'b0, 5'b00000, 12);

        for (int r = 0; r < 100; r++) begin
            rp = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'b0;
            rb = ($urandom_range(0, 3) == 0) ? ~sw_band : sw_band;
            applyStimulus(1'b1, rb, rp, $urandom_range(1, 12));
        end

        applyStimulus(1'b0, 1'b0, 5'b00000, 20);
        @(posedge clk);
        #2;
        checkOutput("hits_drained", 8'(hit_q.size()), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
